// File: rtl/uart_rx_sampler.sv
// UART receive oversampling counter and 3-point majority-vote bit sampler.
// Counts oversample ticks and bits for the RX frame controller and votes each bit at mid-period.
module uart_rx_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic       enable,
  input  logic       data_sampled_en,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       sampled_bit,
  output logic       sample_valid
);

  logic [5:0] ratio;
  logic [5:0] half;
  logic [5:0] last_tick;
  logic [5:0] first_tick;
  logic [5:0] vote_tick;
  logic       wrap;
  logic       vote_hit;
  logic       majority;
  logic [2:0] sample_hit;

  logic [5:0] edge_cnt_q, edge_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       sampled_bit_q, sampled_bit_d;
  logic       sample_valid_q, sample_valid_d;
  logic [2:0] samples_q, samples_d;

  // Unsupported ratios fall back to the smallest legal one.
  always_comb begin
    ratio = 6'd8;
    case (prescale)
      6'd8:    ratio = 6'd8;
      6'd16:   ratio = 6'd16;
      6'd32:   ratio = 6'd32;
      default: ratio = 6'd8;
    endcase
  end

  assign half       = ratio >> 1;
  assign last_tick  = ratio - 6'd1;
  assign first_tick = half - 6'd1;
  assign vote_tick  = half + 6'd2;

  // ">=" rather than "==" so a prescale drop mid-bit cannot strand the counter out of range.
  assign wrap     = (edge_cnt_q >= last_tick);
  assign vote_hit = (edge_cnt_q == vote_tick);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sample_point
      assign sample_hit[gi] = (edge_cnt_q == (first_tick + 6'(gi)));
    end
  endgenerate

  assign majority = (samples_q[0] & samples_q[1]) |
                    (samples_q[0] & samples_q[2]) |
                    (samples_q[1] & samples_q[2]);

  always_comb begin
    edge_cnt_d     = edge_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    samples_d      = samples_q;

    if (!enable) begin
      edge_cnt_d = 6'd0;
      bit_cnt_d  = 4'd0;
    end else begin
      if (wrap) begin
        edge_cnt_d = 6'd0;
        if (bit_cnt_q != 4'hF) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end else begin
        edge_cnt_d = edge_cnt_q + 6'd1;
      end

      if (data_sampled_en) begin
        for (int i = 0; i < 3; i++) begin
          if (sample_hit[i]) begin
            samples_d[i] = rx_in;
          end
        end
        if (vote_hit) begin
          sampled_bit_d  = majority;
          sample_valid_d = 1'b1;
        end
      end
    end
  end

  // Idle-high line: sample points and voted bit reset to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q     <= 6'd0;
      bit_cnt_q      <= 4'd0;
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
      samples_q      <= 3'b111;
    end else begin
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
      samples_q      <= samples_d;
    end
  end

  assign edge_cnt     = edge_cnt_q;
  assign bit_cnt      = bit_cnt_q;
  assign sampled_bit  = sampled_bit_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed, table-driven bench for uart_rx_sampler; each vector lists one cycle's inputs
// and the registered outputs expected during that cycle.
module tb_uart_rx_sampler;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       enable;
  logic       data_sampled_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       sample_valid;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic       rx;
    logic [5:0] ps;
    logic       en;
    logic       dse;
    logic [5:0] e_edge;
    logic [3:0] e_bit;
    logic       e_sb;
    logic       e_sv;
  } vec_t;

  vec_t vecs[$];

  uart_rx_sampler dut (
    .clk             (clk),
    .rst             (rst),
    .rx_in           (rx_in),
    .prescale        (prescale),
    .enable          (enable),
    .data_sampled_en (data_sampled_en),
    .edge_cnt        (edge_cnt),
    .bit_cnt         (bit_cnt),
    .sampled_bit     (sampled_bit),
    .sample_valid    (sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic rx, input logic [5:0] ps, input logic en,
                              input logic dse, input int e_edge, input int e_bit,
                              input logic e_sb, input logic e_sv);
    vec_t v;
    v.rx = rx; v.ps = ps; v.en = en; v.dse = dse;
    v.e_edge = 6'(e_edge); v.e_bit = 4'(e_bit); v.e_sb = e_sb; v.e_sv = e_sv;
    vecs.push_back(v);
  endfunction

  task automatic check(input string tag, input int idx, input logic [5:0] e_edge,
                       input logic [3:0] e_bit, input logic e_sb, input logic e_sv);
    n_vec++;
    $display("%s[%0d] rx=%b ps=%0d en=%b dse=%b -> edge=%0d bit=%0d sb=%b sv=%b",
             tag, idx, rx_in, prescale, enable, data_sampled_en,
             edge_cnt, bit_cnt, sampled_bit, sample_valid);
    if (edge_cnt !== e_edge) begin
      n_miss++;
      $display("FAIL %s[%0d] edge_cnt got %0d want %0d", tag, idx, edge_cnt, e_edge);
    end
    if (bit_cnt !== e_bit) begin
      n_miss++;
      $display("FAIL %s[%0d] bit_cnt got %0d want %0d", tag, idx, bit_cnt, e_bit);
    end
    if (sampled_bit !== e_sb) begin
      n_miss++;
      $display("FAIL %s[%0d] sampled_bit got %b want %b", tag, idx, sampled_bit, e_sb);
    end
    if (sample_valid !== e_sv) begin
      n_miss++;
      $display("FAIL %s[%0d] sample_valid got %b want %b", tag, idx, sample_valid, e_sv);
    end
  endtask

  initial begin
    logic [9:0] frame;
    logic       sb;
    int         k;

    frame = {1'b1, 8'h5A, 1'b0};

    // Idle after reset release: counts stay at zero until enable.
    for (int i = 0; i < 3; i++) add(1, 8, 0, 0, 0, 0, 1, 0);

    // P=8, line held low for three bits.
    for (int i = 0; i < 24; i++) add(0, 8, 1, 1, i % 8, i / 8, (i >= 7) ? 1'b0 : 1'b1, (i % 8) == 7);
    add(0, 8, 0, 1, 0, 3, 0, 0);
    add(0, 8, 0, 1, 0, 0, 0, 0);

    // P=16, single low sample at tick 8 is outvoted.
    for (int i = 0; i < 16; i++) add((i == 8) ? 1'b0 : 1'b1, 16, 1, 1, i, 0, (i >= 11) ? 1'b1 : 1'b0, i == 11);
    add(1, 16, 0, 1, 0, 1, 1, 0);
    add(1, 16, 0, 1, 0, 0, 1, 0);

    // P=16, two of three sample points low wins the vote.
    for (int i = 0; i < 16; i++) add((i == 7 || i == 9) ? 1'b0 : 1'b1, 16, 1, 1, i, 0, (i >= 11) ? 1'b0 : 1'b1, i == 11);
    add(1, 16, 0, 1, 0, 1, 0, 0);
    add(1, 16, 0, 1, 0, 0, 0, 0);

    // Illegal prescale 20 behaves as 8.
    for (int i = 0; i < 10; i++) add(1, 20, 1, 1, i % 8, i / 8, (i >= 7) ? 1'b1 : 1'b0, (i % 8) == 7);
    add(1, 20, 0, 1, 2, 1, 1, 0);
    add(1, 20, 0, 1, 0, 0, 1, 0);

    // 16*P+ cycles with sampling disabled: bit_cnt saturates, no samples taken.
    for (int i = 0; i < 136; i++) add(0, 8, 1, 0, i % 8, (i / 8 > 15) ? 15 : i / 8, 1, 0);
    add(0, 8, 0, 0, 0, 15, 1, 0);
    add(0, 8, 0, 0, 0, 0, 1, 0);

    // P=32 frame: start, 0x5A LSB first, stop.
    for (int i = 0; i < 320; i++) begin
      k = i / 32;
      if ((i % 32) >= 19) sb = frame[k];
      else if (k == 0)    sb = 1'b1;
      else                sb = frame[k-1];
      add(frame[k], 32, 1, 1, i % 32, k, sb, (i % 32) == 19);
    end
    add(1, 32, 0, 1, 0, 10, 1, 0);
    add(1, 32, 0, 1, 0, 0, 1, 0);

    // Prescale drops from 32 to 8 at tick 21: wraps on the next edge.
    for (int i = 0; i < 21; i++) add(0, 32, 1, 0, i, 0, 1, 0);
    add(0, 8, 1, 0, 21, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 8, 1, 0, i, 1, 1, 0);
    add(0, 8, 0, 0, 4, 1, 1, 0);
    add(0, 8, 0, 0, 0, 0, 1, 0);

    // Enable dropped at edge_cnt=4: abort, no pulse, voted bit held.
    for (int i = 0; i < 4; i++) add(0, 8, 1, 1, i, 0, 1, 0);
    add(0, 8, 0, 1, 4, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 8, 0, 1, 0, 0, 1, 0);

    // Enable dropped exactly on the vote tick: still no update.
    for (int i = 0; i < 6; i++) add(0, 8, 1, 1, i, 0, 1, 0);
    add(0, 8, 0, 1, 6, 0, 1, 0);
    for (int i = 0; i < 2; i++) add(0, 8, 0, 1, 0, 0, 1, 0);

    rst = 1'b0; rx_in = 1'b1; prescale = 6'd8; enable = 1'b0; data_sampled_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, 6'd0, 4'd0, 1'b1, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      rx_in = vecs[i].rx;
      prescale = vecs[i].ps;
      enable = vecs[i].en;
      data_sampled_en = vecs[i].dse;
      check("tbl", i, vecs[i].e_edge, vecs[i].e_bit, vecs[i].e_sb, vecs[i].e_sv);
      @(posedge clk);
      #1;
    end

    // Mid-frame asynchronous reset while enable stays high.
    rx_in = 1'b0; prescale = 6'd8; enable = 1'b1; data_sampled_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst", 0, 6'd2, 4'd1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", 0, 6'd0, 4'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("rst_held", 0, 6'd0, 4'd0, 1'b1, 1'b0);
    enable = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", 0, 6'd0, 4'd0, 1'b1, 1'b0);
    enable = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_run", 0, 6'd1, 4'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
